// File: rtl/command_queue.sv
// Circular command buffer between the I2C slave and the TPU. Each queued
// command is re-issued as a single execute pulse once the TPU is not busy.
module command_queue #(
  parameter int DEPTH_LOG2 = 3,
  parameter int WIDTH      = 48
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_execute,
  input  logic [WIDTH-1:0]      in_command,
  output logic                  in_busy,
  output logic                  out_execute,
  output logic [WIDTH-1:0]      out_command,
  input  logic                  out_busy,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, GUARD, WAIT} state_t;

  state_t                  state;
  logic [WIDTH-1:0]        mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wp;
  logic [DEPTH_LOG2-1:0]   rp;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;

  // Full/empty come from the pre-edge level, so a pop cannot make room
  // for a push on the same edge and an empty queue cannot bypass.
  always_comb begin
    full  = (level == FULL_LEVEL);
    empty = (level == '0);
    push  = in_execute && !full;
    pop   = (state == IDLE) && !empty && !out_busy;
  end

  assign in_busy = full;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= in_command;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wp          <= '0;
      rp          <= '0;
      level       <= '0;
      overflow    <= 1'b0;
      out_execute <= 1'b0;
      out_command <= '0;
    end else begin
      out_execute <= 1'b0;
      if (push) wp <= wp + 1'b1;
      if (in_execute && full) overflow <= 1'b1;

      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      unique case (state)
        IDLE: begin
          if (pop) begin
            state       <= ISSUE;
            out_execute <= 1'b1;
            out_command <= mem[rp];
            rp          <= rp + 1'b1;
          end
        end
        ISSUE:   state <= GUARD;
        GUARD:   state <= WAIT;
        WAIT:    if (!out_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_command_queue.sv
// Directed self-checking bench for command_queue: ordering, wrap, overflow,
// simultaneous push/pop, TPU busy handshake and mid-operation reset.
module tb_command_queue;

  localparam int DL = 3;
  localparam int W  = 48;

  localparam logic [W-1:0] CMD1   = 48'h123456ABCDEF;
  localparam logic [W-1:0] O_BASE = 48'hC0DE00000000;
  localparam logic [W-1:0] F_BASE = 48'hF00D00000100;
  localparam logic [W-1:0] A_BASE = 48'hAAAA00000200;
  localparam logic [W-1:0] B_BASE = 48'hBBBB00000300;
  localparam logic [W-1:0] N_BASE = 48'h555500000400;
  localparam logic [W-1:0] R_BASE = 48'hEEEE00000500;
  localparam logic [W-1:0] R_NEW  = 48'h0123456789AB;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_execute;
  logic [W-1:0]  in_command;
  logic          in_busy;
  logic          out_execute;
  logic [W-1:0]  out_command;
  logic          out_busy;
  logic [DL:0]   level;
  logic          overflow;

  int compared   = 0;
  int mismatched = 0;
  int pulse_cnt  = 0;

  logic [W-1:0] got2 [12];

  always #5 clk = ~clk;

  command_queue #(.DEPTH_LOG2(DL), .WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_execute  (in_execute),
    .in_command  (in_command),
    .in_busy     (in_busy),
    .out_execute (out_execute),
    .out_command (out_command),
    .out_busy    (out_busy),
    .level       (level),
    .overflow    (overflow)
  );

  always @(negedge clk) if (out_execute) pulse_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    in_execute = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push_one(input logic [W-1:0] cmd);
    in_execute = 1'b1;
    in_command = cmd;
    tick();
    in_execute = 1'b0;
  endtask

  task automatic wait_pulse(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (out_execute) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    int p0;
    int pe [4];
    int np;

    reset      = 1'b0;
    in_execute = 1'b0;
    in_command = '0;
    out_busy   = 1'b0;

    // Reset values and single command
    do_reset();
    check("rst_level",    level, 0);
    check("rst_in_busy",  in_busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_out_exec", out_execute, 0);
    check("rst_out_cmd",  out_command, 0);
    push_one(CMD1);
    check("t1_level1", level, 1);
    check("t1_noexec", out_execute, 0);
    tick();
    check("t1_exec",   out_execute, 1);
    check("t1_cmd",    out_command, CMD1);
    check("t1_level0", level, 0);
    tick();
    check("t1_pulse_end", out_execute, 0);

    // Ordering and pointer wrap with a slow producer and a busy TPU
    do_reset();
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          push_one(O_BASE + W'(i));
          repeat (5) tick();
        end
      end
      begin
        bit ok2;
        for (int i = 0; i < 12; i++) begin
          wait_pulse(200, ok2);
          check("t2_pulse", ok2, 1);
          got2[i] = out_command;
          tick();
          out_busy = 1'b1;
          repeat (5) tick();
          out_busy = 1'b0;
        end
      end
    join
    for (int i = 0; i < 12; i++) check("t2_order", got2[i], O_BASE + W'(i));
    check("t2_overflow", overflow, 0);

    // Fill, overflow, then drain in order
    do_reset();
    out_busy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      push_one(F_BASE + W'(i));
      if (i == 7) begin
        check("t3_level8",  level, 8);
        check("t3_in_busy", in_busy, 1);
        check("t3_no_ovf",  overflow, 0);
      end
    end
    check("t3_level_held", level, 8);
    check("t3_ovf",        overflow, 1);
    out_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_pulse(20, ok);
      check("t3_pulse", ok, 1);
      check("t3_order", out_command, F_BASE + W'(i));
      if (i == 0) begin
        check("t3_in_busy_fall", in_busy, 0);
        check("t3_level7",       level, 7);
      end
    end
    repeat (4) tick();
    check("t3_drained",   level, 0);
    check("t3_ovf_stick", overflow, 1);

    // Push on the pop edge with level 3
    do_reset();
    out_busy = 1'b1;
    for (int i = 0; i < 3; i++) push_one(A_BASE + W'(i));
    check("t4_level3", level, 3);
    out_busy   = 1'b0;
    in_execute = 1'b1;
    in_command = A_BASE + W'(3);
    tick();
    in_execute = 1'b0;
    out_busy   = 1'b1;
    check("t4_exec",       out_execute, 1);
    check("t4_level_same", level, 3);
    check("t4_cmd",        out_command, A_BASE);

    // Push on the pop edge while full is dropped
    do_reset();
    out_busy = 1'b1;
    for (int i = 0; i < 8; i++) push_one(A_BASE + W'(i));
    check("t4b_level8", level, 8);
    out_busy   = 1'b0;
    in_execute = 1'b1;
    in_command = A_BASE + W'(8);
    tick();
    in_execute = 1'b0;
    check("t4b_level7",  level, 7);
    check("t4b_ovf",     overflow, 1);
    check("t4b_exec",    out_execute, 1);
    check("t4b_in_busy", in_busy, 0);

    // TPU holds busy for 10 cycles after its pulse
    do_reset();
    out_busy = 1'b0;
    push_one(B_BASE);
    push_one(B_BASE + W'(1));
    check("t5_exec0", out_execute, 1);
    check("t5_cmd0",  out_command, B_BASE);
    tick();
    out_busy = 1'b1;
    p0 = pulse_cnt;
    repeat (10) tick();
    out_busy = 1'b0;
    tick();
    check("t5_hold",     out_execute, 0);
    check("t5_no_pulse", pulse_cnt, p0);
    tick();
    check("t5_exec1", out_execute, 1);
    check("t5_cmd1",  out_command, B_BASE + W'(1));

    // TPU never busy: pulses every 4 edges
    do_reset();
    out_busy = 1'b0;
    np = 0;
    for (int c = 0; c < 16; c++) begin
      in_execute = (c < 3);
      in_command = N_BASE + W'(c);
      tick();
      if (out_execute && np < 4) begin
        pe[np] = c;
        np++;
      end
    end
    in_execute = 1'b0;
    check("t5n_count",   np, 3);
    check("t5n_latency", pe[0], 1);
    check("t5n_gap1",    pe[1] - pe[0], 4);
    check("t5n_gap2",    pe[2] - pe[1], 4);

    // Reset while in WAIT with five entries queued
    do_reset();
    out_busy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_execute = 1'b1;
      in_command = R_BASE + W'(c);
      tick();
      if (out_execute) out_busy = 1'b1;
    end
    in_execute = 1'b0;
    check("t6_level5", level, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_exec",    out_execute, 0);
    check("t6_cmd",     out_command, 0);
    check("t6_level",   level, 0);
    check("t6_ovf",     overflow, 0);
    check("t6_in_busy", in_busy, 0);
    out_busy = 1'b0;
    p0 = pulse_cnt;
    repeat (10) tick();
    check("t6_no_pulse", pulse_cnt, p0);
    push_one(R_NEW);
    tick();
    check("t6_new_exec", out_execute, 1);
    check("t6_new_cmd",  out_command, R_NEW);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
